// File: rtl/key_event_if.sv
// key_event_if: event handshake between the key controller and its consumer
interface key_event_if #(parameter int CODE_W = 2);
  logic              ev_valid;
  logic [CODE_W-1:0] ev_code;
  logic              ev_long;
  logic              ev_ready;
  modport master (output ev_valid, ev_code, ev_long, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_long, output ev_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounces raw keys and reports press / long-press events through a valid/ready port
module key_event_ctrl #(
  parameter int N_KEYS     = 4,
  parameter int TICK_W     = 20,
  parameter int STABLE_N   = 4,
  parameter int LONG_TICKS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_key_state,
  output logic              o_ovf,
  key_event_if.master       bus
);
  localparam int CODE_W = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  logic [N_KEYS-1:0]   r_sync1, r_sync2;
  logic [TICK_W-1:0]   r_pre;
  logic [STABLE_N-1:0] r_samp [N_KEYS];
  logic [STABLE_N-1:0] w_samp_nxt [N_KEYS];
  logic [HOLD_W-1:0]   r_hold [N_KEYS];
  logic [N_KEYS-1:0]   r_ks, r_ppend, r_lpend;
  logic [N_KEYS-1:0]   w_press, w_rel, w_lset;
  logic [N_KEYS-1:0]   w_oh, w_pclr, w_lclr, w_pav, w_lav, w_req;
  logic                r_ovf, r_valid, r_long;
  logic [CODE_W-1:0]   r_code, r_last;
  logic [CODE_W-1:0]   w_sel, w_idx;
  logic                w_tick, w_xfer, w_adv, w_found, w_ovf_set;
  assign w_tick = &r_pre;
  genvar k;
  generate
    for (k = 0; k < N_KEYS; k++) begin : g_key
      assign w_samp_nxt[k] = {r_samp[k][STABLE_N-2:0], r_sync2[k]};
      assign w_press[k]    = w_tick & ~r_ks[k] & ~|w_samp_nxt[k];
      assign w_rel[k]      = w_tick & r_ks[k] & (&w_samp_nxt[k]);
      // long press fires once, on the tick the hold count reaches LONG_TICKS, unless the key is releasing
      assign w_lset[k]     = w_tick & r_ks[k] & ~w_rel[k] & (r_hold[k] == HOLD_W'(LONG_TICKS - 1));
    end
  endgenerate
  assign w_xfer    = r_valid & bus.ev_ready;
  assign w_adv     = ~r_valid | bus.ev_ready;
  assign w_oh      = N_KEYS'(1) << r_code;
  assign w_pclr    = (w_xfer & ~r_long) ? w_oh : '0;
  assign w_lclr    = (w_xfer & r_long) ? w_oh : '0;
  assign w_pav     = r_ppend & ~w_pclr;
  assign w_lav     = r_lpend & ~w_lclr;
  assign w_req     = w_pav | w_lav;
  assign w_ovf_set = |(w_press & w_pav) | |(w_lset & w_lav);
  // synchronize raw keys (idle high) and run the sample-tick prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_pre   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_pre   <= r_pre + 1'b1;
    end
  end
  // per-key sample shift, debounced state and saturating hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ks <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_samp[i] <= '1;
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (w_tick) r_samp[i] <= w_samp_nxt[i];
        r_ks[i]   <= w_press[i] ? 1'b1 : w_rel[i] ? 1'b0 : r_ks[i];
        r_hold[i] <= !r_ks[i] ? '0 :
                     (w_tick && r_hold[i] != HOLD_W'(LONG_TICKS)) ? r_hold[i] + 1'b1 : r_hold[i];
      end
    end
  end
  // pending flags: a new event beats a same-cycle clear; a repeat on a live flag is lost and sticks ovf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ppend <= '0;
      r_lpend <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ppend <= w_press | w_pav;
      r_lpend <= w_lset | w_lav;
      r_ovf   <= r_ovf | w_ovf_set;
    end
  end
  // round-robin search starting after the last granted key
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int j = 1; j <= N_KEYS; j++) begin
      w_idx = CODE_W'((int'(r_last) + j) % N_KEYS);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end
  // present the selected event; hold it until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_long  <= 1'b0;
      r_last  <= CODE_W'(N_KEYS - 1);
    end else if (w_adv) begin
      r_valid <= w_found;
      if (w_found) begin
        r_code <= w_sel;
        r_long <= ~w_pav[w_sel];
        r_last <= w_sel;
      end
    end
  end
  assign bus.ev_valid = r_valid;
  assign bus.ev_code  = r_code;
  assign bus.ev_long  = r_long;
  assign o_key_state  = r_ks;
  assign o_ovf        = r_ovf;
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: table-driven key scenarios plus corner sequences, with an event scoreboard
module tb_key_event_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] key_state;
  logic       ovf;
  int         n_cmp = 0;
  int         n_err = 0;
  int         bad;
  typedef struct packed {logic [1:0] code; logic lng;} ev_t;
  typedef struct {int k; int low; bit p; bit l;} vec_t;
  ev_t  exp_q[$];
  vec_t tbl[6];
  key_event_if #(.CODE_W(2)) bus();
  key_event_ctrl #(.N_KEYS(4), .TICK_W(4), .STABLE_N(4), .LONG_TICKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_key(key), .o_key_state(key_state), .o_ovf(ovf), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(int max);
    int i = 0;
    while (!bus.ev_valid && i < max) begin
      @(negedge clk);
      i++;
    end
    chk("valid_seen", int'(bus.ev_valid), 1);
  endtask
  task automatic push(int c, int l);
    ev_t e;
    e.code = 2'(c);
    e.lng  = 1'(l);
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst_n && bus.ev_valid && bus.ev_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got code=%0d long=%0d, expected no event (t=%0t)", bus.ev_code, bus.ev_long, $time);
      end else begin
        e = exp_q.pop_front();
        chk("ev_code", int'(bus.ev_code), int'(e.code));
        chk("ev_long", int'(bus.ev_long), int'(e.lng));
      end
    end
  end
  initial begin
    tbl = '{'{0, 600, 1, 1}, '{2, 100, 1, 0}, '{3, 30, 0, 0},
            '{1, 100, 1, 0}, '{3, 300, 1, 1}, '{2, 12, 0, 0}};
    bus.ev_ready = 1'b1;
    cyc(3);
    chk("rst_key_state", int'(key_state), 0);
    chk("rst_ev_valid", int'(bus.ev_valid), 0);
    chk("rst_ev_code", int'(bus.ev_code), 0);
    chk("rst_ev_long", int'(bus.ev_long), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    cyc(5);
    foreach (tbl[i]) begin
      if (tbl[i].p) push(tbl[i].k, 0);
      if (tbl[i].l) push(tbl[i].k, 1);
      key[tbl[i].k] = 1'b0;
      cyc(tbl[i].low);
      chk("ks_held", int'(key_state[tbl[i].k]), int'(tbl[i].p));
      key[tbl[i].k] = 1'b1;
      cyc(150);
      chk("ks_released", int'(key_state), 0);
      chk("tbl_drain", exp_q.size(), 0);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      key[1] = ~key[1];
      repeat (10) begin
        cyc(1);
        if (key_state[1]) bad++;
      end
    end
    cyc(150);
    chk("bounce_ks", bad, 0);
    chk("bounce_drain", exp_q.size(), 0);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    bus.ev_ready = 1'b0;
    cyc(3);
    key = 4'b0100;
    wait_valid(200);
    key = 4'hF;
    chk("arb_first_code", int'(bus.ev_code), 0);
    chk("arb_first_long", int'(bus.ev_long), 0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.ev_valid || bus.ev_code != 2'd0 || bus.ev_long) bad++;
    end
    chk("stall_stable", bad, 0);
    push(0, 0);
    push(1, 0);
    push(3, 0);
    @(posedge clk);
    #1 bus.ev_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("b2b_valid", int'(bus.ev_valid), 1);
    end
    @(negedge clk);
    chk("b2b_idle", int'(bus.ev_valid), 0);
    cyc(150);
    chk("arb_drain", exp_q.size(), 0);
    bus.ev_ready = 1'b0;
    key[2] = 1'b0;
    cyc(100);
    key[2] = 1'b1;
    cyc(100);
    key[2] = 1'b0;
    cyc(100);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_code", int'(bus.ev_code), 2);
    push(2, 0);
    bus.ev_ready = 1'b1;
    key[2] = 1'b1;
    cyc(150);
    chk("ovf_drain", exp_q.size(), 0);
    chk("ovf_sticky", int'(ovf), 1);
    bus.ev_ready = 1'b0;
    key[3] = 1'b0;
    wait_valid(200);
    key[3] = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", int'(bus.ev_valid), 0);
    chk("mid_rst_code", int'(bus.ev_code), 0);
    chk("mid_rst_long", int'(bus.ev_long), 0);
    chk("mid_rst_key_state", int'(key_state), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    exp_q.delete();
    cyc(3);
    rst_n = 1'b1;
    bus.ev_ready = 1'b1;
    cyc(200);
    chk("post_rst_valid", int'(bus.ev_valid), 0);
    chk("post_rst_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
